zet_wb_f2h_sdram_bridge: RTL and testbench
==========================================

Name: zet_wb_f2h_sdram_bridge

Overview:
- Bridges the Zet CPU's 16-bit Wishbone classic master onto the HPS f2h_sdram0 Avalon-MM port (32-bit data, 30-bit word address).
- Sits directly upstream of the soc_system f2h_sdram0 data interface, in the same clock domain as hps_0_f2h_sdram0_clock.
- Converts each Wishbone cycle into one single-beat Avalon transaction.
- Steers the 16-bit half-word into the correct 32-bit lane.

Parameters:
- BASE_WORD, 30'h0800_0000, Avalon word address of the x86 physical address 0 (byte 0x2000_0000 in HPS DDR).
- WB_AW, 19, Wishbone word-address width (wb_adr_i[19:1], 1 MB x86 space).

Ports:
- clk  in  1  bridge clock; also drives hps_0_f2h_sdram0_clock_clk
- rst_n  in  1  asynchronous active-low reset
- wb_adr_i  in  19  Wishbone half-word address (bits [19:1])
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_sel_i  in  2  byte selects
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- avm_address  out  30  Avalon word address
- avm_burstcount  out  8  always 8'd1
- avm_read  out  1  read command
- avm_write  out  1  write command
- avm_writedata  out  32  write data
- avm_byteenable  out  4  byte enables
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid

Behaviour:
- Reset values, asserted asynchronously on rst_n low: all outputs 0 except avm_burstcount = 1; state = IDLE.
- Address mapping: avm_address = BASE_WORD + wb_adr_i[19:2], computed in 30-bit arithmetic with wrap; half = wb_adr_i[1].
- Lane steering:
  - half=0: byteenable = {2'b00, sel}, writedata = {16'h0, dat}.
  - half=1: byteenable = {sel, 2'b00}, writedata = {dat, 16'h0}.
- Read return: wb_dat_o = half ? readdata[31:16] : readdata[15:0], registered; holds its value until the next read completes.
- FSM states IDLE, WR, RD, RDW, ACK:
  - IDLE: on cyc & stb, latch address, half, sel, data and we. Go to WR (avm_write=1) or RD (avm_read=1) next cycle. sel==2'b00 is still issued, with byteenable 0.
  - WR / RD: hold the command and all command signals stable while avm_waitrequest=1. On the first cycle with waitrequest=0, deassert the command. WR -> ACK; RD -> RDW.
  - RDW: wait for avm_readdatavalid; capture the selected half -> ACK. readdatavalid is ignored in every other state.
  - ACK: wb_ack_o=1 for exactly one cycle if cyc is still high; -> IDLE. The next request cannot start before the cycle after ACK, so a held stb never double-issues.
- Latency with waitrequest=0 and read data returned in N cycles:
  - write: ack 3 cycles after stb sampled.
  - read: ack N+3 cycles after stb sampled.
- cyc dropped mid-transaction: the Avalon command is never withdrawn; the transaction completes and ack is suppressed.
- Reset mid-operation: commands drop immediately. rst_n must be the same reset that holds the f2h port, so no stale readdatavalid arrives afterwards.
- Exactly one outstanding Avalon transaction at any time.

Optional Feature:
- Macro: ZET_F2H_RDCACHE_EN.
- Defined:
  - One-entry cache of the last 32-bit read word: tag = 30-bit address plus a valid bit.
  - A read hit in IDLE goes straight to ACK with the cached half, and issues no Avalon read.
  - A write to the tagged address merges the enabled bytes into the cache.
  - Reset clears valid.
- Undefined: every read goes to Avalon; no cache registers are present.

Decomposition:
- Package zet_f2h_pkg holds:
  - the state enum {IDLE, WR, RD, RDW, ACK};
  - BASE_WORD default;
  - burstcount constant 8'd1;
  - a lane-steering function shared by write and cache-merge paths.
- One sub-module is natural: zet_f2h_rdcache, the single-entry cache, instantiated only under ZET_F2H_RDCACHE_EN. The FSM stays in the top.

Test Plan:
- Write adr=0x12346 (half=1), dat=0xBEEF, sel=2'b11, no wait -> avm_address=0x08004 8D1, byteenable=4'b1100, writedata=0xBEEF_0000, single write pulse, ack 3 cycles after stb.
- Read adr=0x00000, slave returns 0xCAFE_1234 after 5 cycles -> wb_dat_o=0x1234, ack exactly 1 cycle; repeat with adr=0x00002 -> 0xCAFE.
- waitrequest held high 7 cycles during write -> address, data and byteenable stable all 7 cycles; write deasserts the cycle after waitrequest falls; one ack.
- stb held high across ack for back-to-back reads -> exactly two Avalon reads and two acks, never three.
- rst_n asserted while in RDW -> avm_read, avm_write and wb_ack_o go 0 immediately; after release, a fresh read completes normally.
- With ZET_F2H_RDCACHE_EN: read 0x00000, write sel=2'b01 dat=0x0055 to 0x00000, read 0x00000 again -> second read issues no avm_read and returns 0x1255.

Source files
------------

// File: rtl/zet_f2h_pkg.sv
// rtl/zet_f2h_pkg.sv - shared types, constants and lane helpers for the Zet Wishbone to f2h_sdram bridge
package zet_f2h_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDW,
        ACK
    } state_t;

    localparam logic [29:0] BASE_WORD_DEFAULT = 30'h0800_0000;
    localparam logic [7:0]  BURSTCOUNT        = 8'd1;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } lane_t;

    // Place a 16-bit half-word and its byte selects into the 32-bit lane picked by address bit 1.
    function automatic lane_t steer_lane(input logic half, input logic [1:0] sel, input logic [15:0] dat);
        lane_t l;
        if (half) begin
            l.be   = {sel, 2'b00};
            l.data = {dat, 16'h0000};
        end else begin
            l.be   = {2'b00, sel};
            l.data = {16'h0000, dat};
        end
        return l;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [3:0] be,
                                                input logic [31:0] new_word);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/zet_wb_f2h_sdram_bridge_if.sv
// rtl/zet_wb_f2h_sdram_bridge_if.sv - Wishbone classic slave side plus Avalon-MM master side of the bridge
interface zet_wb_f2h_sdram_bridge_if #(
    parameter int WB_AW = 19
);
    logic [WB_AW:1] wb_adr_i;
    logic [15:0]    wb_dat_i;
    logic [15:0]    wb_dat_o;
    logic [1:0]     wb_sel_i;
    logic           wb_we_i;
    logic           wb_stb_i;
    logic           wb_cyc_i;
    logic           wb_ack_o;

    logic [29:0]    avm_address;
    logic [7:0]     avm_burstcount;
    logic           avm_read;
    logic           avm_write;
    logic [31:0]    avm_writedata;
    logic [3:0]     avm_byteenable;
    logic           avm_waitrequest;
    logic [31:0]    avm_readdata;
    logic           avm_readdatavalid;

    // master: the bridge, which masters Avalon and answers Wishbone
    modport master (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o,
        output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o,
        input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/zet_f2h_rdcache.sv
// rtl/zet_f2h_rdcache.sv - single-entry cache of the last 32-bit word read through the bridge
module zet_f2h_rdcache
    import zet_f2h_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        fill_en,
    input  logic [29:0] fill_addr,
    input  logic [31:0] fill_data,
    input  logic        wr_en,
    input  logic [29:0] wr_addr,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data
);
    logic        valid;
    logic [29:0] tag;
    logic [31:0] data;

    assign hit      = valid && (tag == lookup_addr);
    assign hit_data = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (wr_en && valid && (tag == wr_addr)) begin
            // Keep the cached copy coherent with writes passing through to DDR.
            data <= merge_bytes(data, wr_be, wr_data);
        end
    end

endmodule

// File: rtl/zet_wb_f2h_sdram_bridge.sv
// rtl/zet_wb_f2h_sdram_bridge.sv - Zet 16-bit Wishbone to HPS f2h_sdram0 Avalon bridge; ZET_F2H_RDCACHE_EN adds a one-word read cache
module zet_wb_f2h_sdram_bridge
    import zet_f2h_pkg::*;
#(
    parameter logic [29:0] BASE_WORD = BASE_WORD_DEFAULT,
    parameter int          WB_AW     = 19
) (
    input logic                       clk,
    input logic                       rst_n,
    zet_wb_f2h_sdram_bridge_if.master bus
);
    state_t      state;
    logic [29:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        wb_ack;
    logic [15:0] wb_dat;
    logic        half_q;

    logic [29:0] req_word;
    lane_t       req_lane;
    logic        req_go;

    assign req_word = BASE_WORD + 30'(bus.wb_adr_i[WB_AW:2]);
    assign req_lane = steer_lane(bus.wb_adr_i[1], bus.wb_sel_i, bus.wb_dat_i);
    // The ack cycle itself is blocked so a strobe held across ack is not issued twice.
    assign req_go   = (state == IDLE) && bus.wb_cyc_i && bus.wb_stb_i && !wb_ack;

`ifdef ZET_F2H_RDCACHE_EN
    logic        cache_hit;
    logic [31:0] cache_data;

    zet_f2h_rdcache u_rdcache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (req_word),
        .hit         (cache_hit),
        .hit_data    (cache_data),
        .fill_en     ((state == RDW) && bus.avm_readdatavalid),
        .fill_addr   (avm_address),
        .fill_data   (bus.avm_readdata),
        .wr_en       (req_go && bus.wb_we_i),
        .wr_addr     (req_word),
        .wr_be       (req_lane.be),
        .wr_data     (req_lane.data)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            wb_ack         <= 1'b0;
            wb_dat         <= '0;
            half_q         <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_go) begin
                        avm_address    <= req_word;
                        half_q         <= bus.wb_adr_i[1];
                        avm_byteenable <= req_lane.be;
                        avm_writedata  <= req_lane.data;
                        if (bus.wb_we_i) begin
                            avm_write <= 1'b1;
                            state     <= WR;
                        end
`ifdef ZET_F2H_RDCACHE_EN
                        else if (cache_hit) begin
                            wb_dat <= bus.wb_adr_i[1] ? cache_data[31:16] : cache_data[15:0];
                            state  <= ACK;
                        end
`endif
                        else begin
                            avm_read <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    if (!bus.avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= ACK;
                    end
                end
                RD: begin
                    if (!bus.avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= RDW;
                    end
                end
                RDW: begin
                    if (bus.avm_readdatavalid) begin
                        wb_dat <= half_q ? bus.avm_readdata[31:16] : bus.avm_readdata[15:0];
                        state  <= ACK;
                    end
                end
                ACK: begin
                    // A master that dropped cyc mid-transfer gets no ack.
                    wb_ack <= bus.wb_cyc_i;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.avm_address    = avm_address;
    assign bus.avm_burstcount = BURSTCOUNT;
    assign bus.avm_read       = avm_read;
    assign bus.avm_write      = avm_write;
    assign bus.avm_writedata  = avm_writedata;
    assign bus.avm_byteenable = avm_byteenable;
    assign bus.wb_ack_o       = wb_ack;
    assign bus.wb_dat_o       = wb_dat;

endmodule

// File: tb/tb_zet_wb_f2h_sdram_bridge.sv
// tb/tb_zet_wb_f2h_sdram_bridge.sv - self-checking bench for zet_wb_f2h_sdram_bridge
module tb_zet_wb_f2h_sdram_bridge;

    localparam logic [29:0] BASE = 30'h0800_0000;

    logic clk;
    logic rst_n;

    zet_wb_f2h_sdram_bridge_if #(.WB_AW(19)) bus ();

    zet_wb_f2h_sdram_bridge #(.BASE_WORD(BASE), .WB_AW(19)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          we;
        logic [19:0] addr;
        logic [15:0] dat;
        logic [1:0]  sel;
        int          waitc;
        int          lat;
        logic [29:0] e_adr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [15:0] e_rdata;
        int          e_lat;
        int          e_rd;
        int          e_wr;
    } vec_t;

    // Avalon slave model state
    logic [31:0] mem [logic [29:0]];
    int          wait_cfg = 0;
    int          lat_cfg  = 1;
    int          wleft    = 0;
    int          pend     = 0;
    logic [29:0] pend_addr;
    int          cnt_rd   = 0;
    int          cnt_wr   = 0;
    int          ack_cnt  = 0;
    int          stab_bad = 0;
    int          cyc_n    = 0;
    bit          prev_cmd = 0;
    logic [69:0] snap;

    // Reference model state
    logic [31:0] ref_mem [logic [29:0]];
    bit          rc_valid = 0;
    logic [29:0] rc_tag   = '0;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] slave_word(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    always begin
        @(posedge clk);
        #1;
        cyc_n++;
        if (bus.wb_ack_o) ack_cnt++;
        bus.avm_readdatavalid = 1'b0;
        if (!rst_n) begin
            pend = 0;
            bus.avm_waitrequest = 1'b0;
            prev_cmd = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata = slave_word(pend_addr);
                end
            end
            if (bus.avm_read || bus.avm_write) begin
                if (!prev_cmd)
                    snap = {bus.avm_address, bus.avm_writedata, bus.avm_byteenable, bus.avm_read, bus.avm_write};
                else if (snap != {bus.avm_address, bus.avm_writedata, bus.avm_byteenable, bus.avm_read, bus.avm_write})
                    stab_bad++;
                prev_cmd = 1;
                if (wleft > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    wleft--;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    prev_cmd = 0;
                    if (bus.avm_write) begin
                        cnt_wr++;
                        mem[bus.avm_address] = slave_word(bus.avm_address);
                        for (int i = 0; i < 4; i++)
                            if (bus.avm_byteenable[i]) mem[bus.avm_address][i*8 +: 8] = bus.avm_writedata[i*8 +: 8];
                    end else begin
                        cnt_rd++;
                        pend_addr = bus.avm_address;
                        pend = lat_cfg;
                    end
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
                prev_cmd = 0;
                wleft = wait_cfg;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input string nm, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.wb_ack_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no ack within 200 cycles", nm);
        end
    endtask

    task automatic drive_req(input bit we, input logic [19:0] addr, input logic [15:0] dat, input logic [1:0] sel);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = addr[19:1];
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
    endtask

    task automatic xfer(input vec_t v, input string nm);
        int rd0, wr0, a0, t0;
        bit ok;
        wait_cfg = v.waitc;
        lat_cfg  = v.lat;
        tick();
        rd0 = cnt_rd; wr0 = cnt_wr; a0 = ack_cnt; t0 = cyc_n;
        drive_req(v.we, v.addr, v.dat, v.sel);
        wait_ack(nm, ok);
        if (ok) begin
            chk({nm, " ack_latency"}, 32'(cyc_n - t0), 32'(v.e_lat));
            chk({nm, " address"}, 32'(bus.avm_address), 32'(v.e_adr));
            chk({nm, " byteenable"}, 32'(bus.avm_byteenable), 32'(v.e_be));
            if (v.we) chk({nm, " writedata"}, bus.avm_writedata, v.e_wdata);
            else      chk({nm, " readdata"}, 32'(bus.wb_dat_o), 32'(v.e_rdata));
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick();
        chk({nm, " ack_one_cycle"}, 32'(bus.wb_ack_o), 32'd0);
        chk({nm, " avm_reads"}, 32'(cnt_rd - rd0), 32'(v.e_rd));
        chk({nm, " avm_writes"}, 32'(cnt_wr - wr0), 32'(v.e_wr));
        chk({nm, " acks"}, 32'(ack_cnt - a0), 32'd1);
    endtask

    // Update the reference model with a completed transfer, computed from the address map rules.
    task automatic ref_apply(input bit we, input logic [19:0] addr, input logic [15:0] dat, input logic [1:0] sel);
        logic [29:0] w;
        logic [31:0] cur;
        w = BASE + 30'(addr[19:2]);
        if (we) begin
            cur = ref_word(w);
            for (int b = 0; b < 2; b++)
                if (sel[b]) cur[(addr[1] ? 16 : 0) + b*8 +: 8] = dat[b*8 +: 8];
            ref_mem[w] = cur;
        end else begin
            rc_valid = 1;
            rc_tag   = w;
        end
    endtask

    task automatic ref_xfer(input bit we, input logic [19:0] addr, input logic [15:0] dat, input logic [1:0] sel,
                            input int waitc, input int lat, input string nm);
        vec_t v;
        bit hit;
        logic [31:0] word;
        v.we = we; v.addr = addr; v.dat = dat; v.sel = sel; v.waitc = waitc; v.lat = lat;
        v.e_adr   = BASE + 30'(addr >> 2);
        v.e_be    = addr[1] ? 4'(sel) << 2 : 4'(sel);
        v.e_wdata = addr[1] ? 32'(dat) << 16 : 32'(dat);
        word      = ref_word(v.e_adr);
        v.e_rdata = addr[1] ? word[31:16] : word[15:0];
`ifdef ZET_F2H_RDCACHE_EN
        hit = !we && rc_valid && (rc_tag == v.e_adr);
`else
        hit = 0;
`endif
        v.e_lat = we ? 3 + waitc : (hit ? 2 : 3 + waitc + lat);
        v.e_rd  = (!we && !hit) ? 1 : 0;
        v.e_wr  = we ? 1 : 0;
        xfer(v, nm);
        ref_apply(we, addr, dat, sel);
    endtask

    vec_t tbl[8];

    initial begin
        int rd0, a0;
        bit ok;
        logic [15:0] got1, got2, exp1, exp2;
        logic [31:0] w;

        tbl[0] = '{1, 20'h12346, 16'hBEEF, 2'b11, 0, 1, 30'h0800_48D1, 4'b1100, 32'hBEEF_0000, 16'h0, 3, 0, 1};
        tbl[1] = '{0, 20'h00000, 16'h0000, 2'b11, 0, 5, 30'h0800_0000, 4'b0011, 32'h0, 16'h1234, 8, 1, 0};
        tbl[2] = '{0, 20'h00002, 16'h0000, 2'b11, 0, 5, 30'h0800_0000, 4'b1100, 32'h0, 16'hCAFE, 8, 1, 0};
        tbl[3] = '{1, 20'h00104, 16'h1357, 2'b01, 7, 1, 30'h0800_0041, 4'b0001, 32'h0000_1357, 16'h0, 10, 0, 1};
        tbl[4] = '{1, 20'h00006, 16'hAAAA, 2'b00, 0, 1, 30'h0800_0001, 4'b0000, 32'hAAAA_0000, 16'h0, 3, 0, 1};
        tbl[5] = '{0, 20'hFFFFE, 16'h0000, 2'b10, 2, 1, 30'h0803_FFFF, 4'b1000, 32'h0, 16'h89AB, 6, 1, 0};
        tbl[6] = '{0, 20'h00104, 16'h0000, 2'b11, 0, 2, 30'h0800_0041, 4'b0011, 32'h0, 16'h0057, 5, 1, 0};
        tbl[7] = '{0, 20'h00006, 16'h0000, 2'b01, 0, 1, 30'h0800_0001, 4'b0100, 32'h0, 16'h5A5B, 4, 1, 0};
`ifdef ZET_F2H_RDCACHE_EN
        tbl[2].e_lat = 2;
        tbl[2].e_rd  = 0;
`endif

        mem[30'h0800_0000]     = 32'hCAFE_1234;
        mem[30'h0803_FFFF]     = 32'h89AB_CDEF;
        ref_mem[30'h0800_0000] = 32'hCAFE_1234;
        ref_mem[30'h0803_FFFF] = 32'h89AB_CDEF;

        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.avm_waitrequest = 0; bus.avm_readdata = '0; bus.avm_readdatavalid = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset avm_address", 32'(bus.avm_address), 32'd0);
        chk("reset avm_read", 32'(bus.avm_read), 32'd0);
        chk("reset avm_write", 32'(bus.avm_write), 32'd0);
        chk("reset avm_writedata", bus.avm_writedata, 32'd0);
        chk("reset avm_byteenable", 32'(bus.avm_byteenable), 32'd0);
        chk("reset avm_burstcount", 32'(bus.avm_burstcount), 32'd1);
        chk("reset wb_ack_o", 32'(bus.wb_ack_o), 32'd0);
        chk("reset wb_dat_o", 32'(bus.wb_dat_o), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i], $sformatf("vec%0d", i));
            ref_apply(tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].sel);
            chk($sformatf("vec%0d burstcount", i), 32'(bus.avm_burstcount), 32'd1);
        end

`ifdef ZET_F2H_RDCACHE_EN
        rd0 = cnt_rd;
        ref_xfer(0, 20'h00000, 16'h0, 2'b11, 0, 3, "cache_rd1");
        ref_xfer(1, 20'h00000, 16'h0055, 2'b01, 0, 1, "cache_wr");
        ref_xfer(0, 20'h00000, 16'h0, 2'b11, 0, 3, "cache_rd2");
        chk("cache_rd2 value", 32'(bus.wb_dat_o), 32'h1255);
`endif

        // Strobe held high across the first ack: two reads, never three.
        wait_cfg = 0; lat_cfg = 2;
        w = ref_word(BASE + 30'h10); exp1 = w[15:0];
        w = ref_word(BASE + 30'h12); exp2 = w[15:0];
        tick();
        rd0 = cnt_rd; a0 = ack_cnt;
        drive_req(0, 20'h00040, 16'h0, 2'b11);
        wait_ack("b2b first", ok);
        got1 = bus.wb_dat_o;
        bus.wb_adr_i = 19'(20'h00048 >> 1);
        wait_ack("b2b second", ok);
        got2 = bus.wb_dat_o;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        repeat (8) tick();
        chk("b2b data1", 32'(got1), 32'(exp1));
        chk("b2b data2", 32'(got2), 32'(exp2));
        chk("b2b avm_reads", 32'(cnt_rd - rd0), 32'd2);
        chk("b2b acks", 32'(ack_cnt - a0), 32'd2);
        ref_apply(0, 20'h00040, 16'h0, 2'b11);
        ref_apply(0, 20'h00048, 16'h0, 2'b11);

        // cyc dropped mid-write: transfer still completes, ack suppressed.
        wait_cfg = 2;
        tick();
        rd0 = cnt_wr; a0 = ack_cnt;
        drive_req(1, 20'h00050, 16'h1111, 2'b11);
        tick();
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        repeat (8) tick();
        chk("cycdrop avm_writes", 32'(cnt_wr - rd0), 32'd1);
        chk("cycdrop acks", 32'(ack_cnt - a0), 32'd0);
        ref_apply(1, 20'h00050, 16'h1111, 2'b11);

        // Reset while a read is stalled by waitrequest.
        wait_cfg = 50;
        tick();
        drive_req(0, 20'h00060, 16'h0, 2'b11);
        tick(); tick();
        chk("rst_rd read_before", 32'(bus.avm_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd read_after", 32'(bus.avm_read), 32'd0);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        wait_cfg = 0;
        tick(); tick();
        rst_n = 1'b1;
        rc_valid = 0;

        // Reset while waiting for read data.
        lat_cfg = 20;
        tick();
        drive_req(0, 20'h00060, 16'h0, 2'b11);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_rdw avm_read", 32'(bus.avm_read), 32'd0);
        chk("rst_rdw avm_write", 32'(bus.avm_write), 32'd0);
        chk("rst_rdw wb_ack_o", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_rdw wb_dat_o", 32'(bus.wb_dat_o), 32'd0);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        tick(); tick();
        rst_n = 1'b1;
        rc_valid = 0;
        ref_xfer(0, 20'h00060, 16'h0, 2'b11, 0, 2, "post_reset_rd");

        for (int i = 0; i < 40; i++) begin
            ref_xfer(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15) * 2), 16'($urandom),
                     2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(1, 4),
                     $sformatf("rand%0d", i));
        end

        chk("command stability under waitrequest", 32'(stab_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
